// File: rtl/cla_seq_adder.sv
// Multi-cycle add/subtract unit. One 4-bit carry-lookahead slice is reused
// across a WIDTH-bit operation, one nibble per clock, LSB first. The carry
// between slices is registered, and valid/ready handshakes sit on both sides.

// 4-bit carry-lookahead slice with group propagate/generate outputs.
module cla_adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       pg,
  output logic       gg
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  // Lookahead carries, sum and group terms, all flattened from g/p.
  always_comb begin
    // NOTE: combinational logic uses blocking '=' so later lines see the
    // values computed above them in the same evaluation.
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    sum  = p ^ c;
    pg   = &p;
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  end

endmodule

module cla_seq_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / 4;
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [IW-1:0]    idx;
  logic             zero_acc;

  logic [3:0] slice_sum;
  logic       slice_pg;
  logic       slice_gg;
  logic       carry_nxt;
  logic       accept;
  logic       last_slice;

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign accept     = in_ready & in_valid;
  assign last_slice = (state == RUN) && (idx == LAST);
  assign carry_nxt  = slice_gg | (slice_pg & carry_q);

  cla_adder4 u_slice (
    .a   (a_q[{idx, 2'b00} +: 4]),
    .b   (b_q[{idx, 2'b00} +: 4]),
    .cin (carry_q),
    .sum (slice_sum),
    .pg  (slice_pg),
    .gg  (slice_gg)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: accept in IDLE, walk N slices in RUN, hold in DONE.
  always_comb begin
    // NOTE: defaulting state_nxt first means every path assigns it, so no
    // latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)   state_nxt = RUN;
      RUN:     if (idx == LAST) state_nxt = DONE;
      DONE:    if (out_ready)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture; subtraction stores the inverted B and injects carry 1.
  always_ff @(posedge clk) begin
    // NOTE: operand registers are left out of reset; they are only read in
    // RUN, which is always preceded by a load.
    if (accept) begin
      a_q <= a;
      b_q <= b ^ {WIDTH{sub}};
    end
  end

  // Slice sequencing, result assembly and flag capture on the final slice.
  always_ff @(posedge clk) begin
    if (rst) begin
      result   <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
      zero     <= 1'b0;
      carry_q  <= 1'b0;
      idx      <= '0;
      zero_acc <= 1'b0;
    end else if (accept) begin
      carry_q  <= sub;
      idx      <= '0;
      zero_acc <= 1'b1;
    end else if (state == RUN) begin
      result[{idx, 2'b00} +: 4] <= slice_sum;
      carry_q  <= carry_nxt;
      zero_acc <= zero_acc & (slice_sum == 4'h0);
      if (last_slice) begin
        cout <= carry_nxt;
        ovf  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) & (slice_sum[3] != a_q[WIDTH-1]);
        zero <= zero_acc & (slice_sum == 4'h0);
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Self-checking bench for cla_seq_adder at WIDTH=32 and WIDTH=8. Each width
// runs directed cases followed by a randomized regression; expected results
// are queued at acceptance and compared when out_valid first rises.
module tb_cla_seq_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total   = 0;
  int bad     = 0;
  int fin_cnt = 0;

  typedef struct {
    logic [31:0] res;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          acc_edge;
  } exp_t;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic c, input logic o, input logic z);
    exp_t e;
    e.res      = r;
    e.cout     = c;
    e.ovf      = o;
    e.zero     = z;
    e.acc_edge = 0;
    return e;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g
    localparam int W    = (gi == 0) ? 32 : 8;
    localparam int N    = W / 4;
    localparam int RIDX = (N > 3) ? 3 : N - 1;
    localparam string PFX = (gi == 0) ? "w32_" : "w8_";

    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic         zero;

    int   cyc     = 0;
    int   or_mode = 0;
    bit   ov_seen = 0;
    exp_t sb[$];

    cla_seq_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero)
    );

    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [W-1:0] ONES   = {W{1'b1}};
    localparam logic [W-1:0] MINNEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] MAXPOS = {1'b0, {(W-1){1'b1}}};

    // Behavioural reference: plain integer add/subtract, flags from signs.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      logic [W:0] full;
      logic       rs;
      exp_t       e;
      full = s ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
      rs   = full[W-1];
      e.res      = 32'(full[W-1:0]);
      e.cout     = s ? (x >= y) : full[W];
      e.ovf      = s ? ((x[W-1] != y[W-1]) && (rs != x[W-1]))
                     : ((x[W-1] == y[W-1]) && (rs != x[W-1]));
      e.zero     = (full[W-1:0] == '0);
      e.acc_edge = 0;
      return e;
    endfunction

    function automatic logic [W-1:0] rand_op();
      case ($urandom_range(0, 7))
        0:       return '0;
        1:       return ONES;
        2:       return MINNEG;
        3:       return MAXPOS;
        4:       return W'(1);
        default: return W'({$urandom, $urandom});
      endcase
    endfunction

    // Drive one operation, hold it until accepted, then queue its expectation.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input exp_t e);
      int waited = 0;
      @(negedge clk);
      a = x;
      b = y;
      sub = s;
      in_valid = 1'b1;
      while (!in_ready && waited < 2000) begin
        @(negedge clk);
        waited++;
      end
      if (!in_ready) begin
        check({PFX, "accept_timeout"}, 0, 1);
        in_valid = 1'b0;
        return;
      end
      e.acc_edge = cyc + 1;
      sb.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
    endtask

    task automatic wait_drain();
      int k = 0;
      while ((sb.size() != 0 || !in_ready) && k < 500) begin
        @(negedge clk);
        k++;
      end
      if (sb.size() != 0 || !in_ready) check({PFX, "drain_timeout"}, 0, 1);
    endtask

    // Output monitor and consumer: compares on the first out_valid cycle of
    // each result and drives out_ready for the coming edge.
    initial begin
      exp_t e;
      out_ready = 1'b0;
      forever begin
        @(negedge clk);
        if (out_valid && !ov_seen) begin
          ov_seen = 1'b1;
          if (sb.size() == 0) begin
            check({PFX, "unexpected_out"}, 1, 0);
          end else begin
            e = sb.pop_front();
            check({PFX, "result"},  result, e.res[W-1:0]);
            check({PFX, "cout"},    cout,   e.cout);
            check({PFX, "ovf"},     ovf,    e.ovf);
            check({PFX, "zero"},    zero,   e.zero);
            check({PFX, "latency"}, cyc - e.acc_edge, N);
          end
        end
        if (!out_valid) ov_seen = 1'b0;
        case (or_mode)
          0:       out_ready = 1'b1;
          1:       out_ready = 1'b0;
          default: out_ready = ($urandom_range(0, 2) != 0);
        endcase
      end
    end

    // Stimulus: reset, directed cases, then randomized regression.
    initial begin
      exp_t         e1;
      exp_t         e2;
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic         s;
      int           t;

      rst = 1'b1;
      in_valid = 1'b0;
      a = '0;
      b = '0;
      sub = 1'b0;
      repeat (2) @(negedge clk);
      check({PFX, "rst_in_ready"},  in_ready,  1);
      check({PFX, "rst_out_valid"}, out_valid, 0);
      check({PFX, "rst_result"},    result,    0);
      check({PFX, "rst_flags"},     {cout, ovf, zero}, 0);
      rst = 1'b0;

      // Add with wrap, plus handshake timing.
      or_mode = 0;
      send(W'(1), ONES, 1'b0, mk(32'h0, 1'b1, 1'b0, 1'b1));
      for (int i = 0; i <= N; i++) begin
        check({PFX, "wrap_in_ready_low"}, in_ready, 0);
        check({PFX, "wrap_out_valid"}, out_valid, (i == N));
        @(negedge clk);
      end
      check({PFX, "wrap_in_ready_back"}, in_ready, 1);

      // Signed overflow on add, then the subtract cases.
      send(MAXPOS, W'(1), 1'b0, mk(32'(MINNEG), 1'b0, 1'b1, 1'b0));
      send(W'(5), W'(7), 1'b1, mk(32'(ONES - W'(1)), 1'b0, 1'b0, 1'b0));
      send(MINNEG, W'(1), 1'b1, mk(32'(MAXPOS), 1'b1, 1'b1, 1'b0));
      send(W'(9), W'(9), 1'b1, mk(32'h0, 1'b1, 1'b0, 1'b1));
      wait_drain();

      // Backpressure: DONE held 5 cycles while a second request waits.
      or_mode = 1;
      x  = W'(32'h1234_5678);
      y  = W'(32'h0F0F_0F0F);
      e1 = model(x, y, 1'b0);
      send(x, y, 1'b0, e1);
      t = 0;
      while (!out_valid && t < 50) begin
        @(negedge clk);
        t++;
      end
      a = W'(32'h0000_0100);
      b = W'(32'h0000_0011);
      sub = 1'b1;
      in_valid = 1'b1;
      for (int j = 0; j < 5; j++) begin
        check({PFX, "bp_in_ready"},  in_ready,  0);
        check({PFX, "bp_out_valid"}, out_valid, 1);
        check({PFX, "bp_result"},    result,    e1.res[W-1:0]);
        check({PFX, "bp_flags"},     {cout, ovf, zero}, {e1.cout, e1.ovf, e1.zero});
        @(negedge clk);
      end
      or_mode = 0;
      e2 = model(W'(32'h0000_0100), W'(32'h0000_0011), 1'b1);
      send(W'(32'h0000_0100), W'(32'h0000_0011), 1'b1, e2);
      wait_drain();

      // Reset mid-operation aborts it; a following operation still works.
      send(W'(32'hDEAD_BEEF), W'(32'h1357_9BDF), 1'b0, model(W'(32'hDEAD_BEEF), W'(32'h1357_9BDF), 1'b0));
      repeat (RIDX) @(negedge clk);
      check({PFX, "idx_before_rst"}, dut.idx, RIDX);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      check({PFX, "abort_in_ready"},  in_ready,  1);
      check({PFX, "abort_out_valid"}, out_valid, 0);
      check({PFX, "abort_result"},    result,    0);
      check({PFX, "abort_flags"},     {cout, ovf, zero}, 0);
      send(W'(3), W'(4), 1'b0, mk(32'd7, 1'b0, 1'b0, 1'b0));
      wait_drain();

      // Randomized regression with input gaps and output stalls.
      or_mode = 2;
      repeat (1000) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        x = rand_op();
        y = rand_op();
        s = 1'($urandom_range(0, 1));
        send(x, y, s, model(x, y, s));
      end
      wait_drain();
      fin_cnt++;
    end
  end

  initial begin
    int k = 0;
    while (fin_cnt < 2 && k < 80000) begin
      @(posedge clk);
      k++;
    end
    if (fin_cnt < 2) check("global_timeout", 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
